// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the debounce_array button conditioner.
package debounce_pkg;
  localparam int DEB_MAX_CH           = 32;
  localparam int DEB_DEF_TICK_DIV     = 100000;
  localparam int DEB_DEF_STABLE_TICKS = 10;

  // Counter width able to hold values 0..n-1; never returns less than 1.
  function automatic int deb_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, tick-qualified stability counter, level and edge pulses.
// Optional auto-repeat on held press when DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_TICKS   = DEB_DEF_STABLE_TICKS,
`ifdef DEBOUNCE_REPEAT_EN
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_PERIOD  = 10,
`endif
  parameter bit ACTIVE_LOW_BIT = 1'b0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int CNT_W = deb_width(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   s;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int REP_W = deb_width(REPEAT_DELAY + REPEAT_PERIOD + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_nxt;
`endif

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw};
    s         = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_BIT;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
        level_d   = s;
        cnt_d     = '0;
        press_d   = s;
        release_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef DEBOUNCE_REPEAT_EN
    // Counter folds back to REPEAT_DELAY so it stays bounded while the button is held.
    rep_d   = rep_q;
    rep_nxt = rep_q + 1'b1;
    if (!level_d) begin
      rep_d = '0;
    end else if (tick && level_q) begin
      if (rep_nxt == REP_W'(REPEAT_DELAY + REPEAT_PERIOD))
        rep_nxt = REP_W'(REPEAT_DELAY);
      rep_d = rep_nxt;
      if (rep_nxt == REP_W'(REPEAT_DELAY))
        press_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef DEBOUNCE_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/debounce_array.sv
// N-channel button conditioner with a shared sample-tick prescaler.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a button is held.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter int                SYNC_STAGES   = 2,
  parameter int                TICK_DIV      = DEB_DEF_TICK_DIV,
  parameter int                STABLE_TICKS  = DEB_DEF_STABLE_TICKS,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW    = '0,
  parameter int                REPEAT_DELAY  = 50,
  parameter int                REPEAT_PERIOD = 10
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] button_in_raw,
  output logic [NUM_CH-1:0] button_level,
  output logic [NUM_CH-1:0] button_press,
  output logic [NUM_CH-1:0] button_release,
  output logic              sample_tick
);
  localparam int PW = deb_width(TICK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // Tick is registered so it is cleanly low throughout reset.
  always_comb begin
    presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_TICKS  (STABLE_TICKS),
`ifdef DEBOUNCE_REPEAT_EN
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
`endif
      .ACTIVE_LOW_BIT(ACTIVE_LOW[i])
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .tick     (tick_q),
      .raw      (button_in_raw[i]),
      .level_o  (button_level[i]),
      .press_o  (button_press[i]),
      .release_o(button_release[i])
    );
  end
endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array: vector table, corner-case sequences and random stimulus.
module tb_debounce_array;
  localparam int         NUM_CH   = 4;
  localparam int         SYNC     = 2;
  localparam int         TDIV     = 4;
  localparam int         STABLE   = 3;
  localparam logic [3:0] AL       = 4'b1000;
  localparam int         RDELAY   = 5;
  localparam int         RPERIOD  = 2;
`ifdef DEBOUNCE_REPEAT_EN
  localparam int         EXP_REPEATS = 8;
`else
  localparam int         EXP_REPEATS = 0;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button_in_raw = 4'hF;
  logic [3:0] button_level, button_press, button_release;
  logic       sample_tick;

  debounce_array #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .TICK_DIV(TDIV), .STABLE_TICKS(STABLE),
    .ACTIVE_LOW(AL), .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clk_in(clk_in), .reset(reset), .button_in_raw(button_in_raw),
    .button_level(button_level), .button_press(button_press),
    .button_release(button_release), .sample_tick(sample_tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_cnt [NUM_CH];
  int rel_cyc [NUM_CH];

  // Reference model state: raw history, per-channel level, mismatch run and held time.
  logic [3:0] hist [SYNC];
  logic [3:0] m_lvl = '0, m_press = '0, m_rel = '0;
  logic       m_tick = 1'b0;
  int         m_run [NUM_CH];
  int         m_held [NUM_CH];
  int         m_n = 0;

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] exp_level;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic s;
    bit   flipped;
    if (reset) begin
      for (int k = 0; k < SYNC; k++) hist[k] = '0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_tick = 1'b0; m_n = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      m_press = '0; m_rel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        s = hist[SYNC-1][i] ^ AL[i];
        flipped = 1'b0;
        if (m_tick) begin
          if (s != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
              m_lvl[i] = s; m_run[i] = 0; m_held[i] = 0; flipped = 1'b1;
              if (s) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
`ifdef DEBOUNCE_REPEAT_EN
          if (m_lvl[i] && !flipped) begin
            m_held[i]++;
            if (m_held[i] == RDELAY || (m_held[i] > RDELAY && (m_held[i] - RDELAY) % RPERIOD == 0))
              m_press[i] = 1'b1;
          end
`endif
        end
      end
      for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = button_in_raw;
      m_n++;
      m_tick = ((m_n % TDIV) == TDIV - 1);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    cyc++;
    check("level", button_level, m_lvl);
    check("press", button_press, m_press);
    check("release", button_release, m_rel);
    check("sample_tick", sample_tick, m_tick);
    for (int i = 0; i < NUM_CH; i++) begin
      if (button_press[i]) press_cnt[i]++;
      if (button_release[i] && rel_cyc[i] < 0) rel_cyc[i] = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NUM_CH; i++) begin press_cnt[i] = 0; rel_cyc[i] = -1; end
  endtask

  initial begin
    int waited;
    vecs[0] = '{4'h8, 20, 4'h0};
    vecs[1] = '{4'h9, 20, 4'h1};
    vecs[2] = '{4'hD, 20, 4'h5};
    vecs[3] = '{4'h8, 20, 4'h0};
    vecs[4] = '{4'h0, 20, 4'h8};
    vecs[5] = '{4'h7, 20, 4'hF};
    vecs[6] = '{4'h8, 20, 4'h0};
    vecs[7] = '{4'h9, 5,  4'h0};
    vecs[8] = '{4'h8, 20, 4'h0};
    clear_counts();

    // Reset held with all raw inputs high.
    run(3);
    check("rst_level", button_level, 4'h0);
    check("rst_press", button_press, 4'h0);
    check("rst_release", button_release, 4'h0);
    check("rst_tick", sample_tick, 1'b0);
    reset = 1'b0;
    button_in_raw = 4'h8;
    run(20);
    check("idle_active_low", button_level, 4'h0);

    foreach (vecs[v]) begin
      button_in_raw = vecs[v].raw;
      run(vecs[v].cycles);
      check("table_level", button_level, vecs[v].exp_level);
    end

    // Clean press on channel 0.
    clear_counts();
    button_in_raw = 4'h9;
    run(24);
    check("clean_press_cnt", press_cnt[0], 1);
    check("clean_level", button_level[0], 1'b1);

    // Bouncing channel 1: 5-cycle segments never span three ticks.
    clear_counts();
    for (int k = 0; k < 8; k++) begin
      button_in_raw[1] = (k % 2 == 0);
      run(5);
    end
    check("bounce_no_press", press_cnt[1], 0);
    button_in_raw[1] = 1'b1;
    run(24);
    check("bounce_one_press", press_cnt[1], 1);

    // Simultaneous release of channels 0 and 2.
    button_in_raw = 4'hD;
    run(24);
    check("pre_release_level", button_level, 4'h5);
    clear_counts();
    button_in_raw = 4'h8;
    run(24);
    check("release_same_cycle", (rel_cyc[0] >= 0) && (rel_cyc[0] == rel_cyc[2]), 1);
    check("release_level", button_level, 4'h0);

    // Active-low channel 3.
    clear_counts();
    button_in_raw = 4'h0;
    run(24);
    check("al_press_cnt", press_cnt[3], 1);
    check("al_level", button_level[3], 1'b1);
    button_in_raw = 4'h8;
    run(24);
    check("al_release_level", button_level[3], 1'b0);

    // Long hold on channel 0: repeats only with the auto-repeat build.
    button_in_raw = 4'h9;
    waited = 0;
    while (!button_level[0] && waited < 30) begin cycle(); waited++; end
    check("hold_rise_timeout", button_level[0], 1'b1);
    clear_counts();
    run(20 * TDIV);
    check("hold_repeat_cnt", press_cnt[0], EXP_REPEATS);
    button_in_raw = 4'h8;
    run(24);
    check("hold_release_level", button_level[0], 1'b0);

    // Reset in the middle of a debounce count.
    clear_counts();
    button_in_raw = 4'h9;
    run(6);
    reset = 1'b1;
    run(2);
    check("midrst_level", button_level, 4'h0);
    check("midrst_press", button_press, 4'h0);
    reset = 1'b0;
    button_in_raw = 4'h8;
    run(24);
    check("midrst_no_press", press_cnt[0], 0);
    check("midrst_level_after", button_level, 4'h0);

    // Random stimulus against the model.
    for (int k = 0; k < 80; k++) begin
      button_in_raw = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 39) == 0);
      run($urandom_range(1, 14));
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
